word_serializer: RTL and testbench

- Parallel-to-serial shift-out stage; consumes WIDTH-bit words, typically bit-reversed by the preceding bit-order reversal stage, and emits them one bit per handshake, LSB first.
- Valid/ready on both sides; zero-bubble streaming of back-to-back words.
- Sits between word-level datapath logic and serial line drivers (SPI-like / bit-banged outputs).

---
 rtl/word_serializer.sv | 89 ++++++++
 tb/tb_word_serializer.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/word_serializer.sv
// Parallel-to-serial shift-out stage: WIDTH-bit words leave LSB first, one bit per handshake.
// Define WORD_SERIALIZER_PARITY_EN to append an even-parity bit after the data MSB.
module word_serializer #(
    parameter int   WIDTH      = 8,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             sout,
    output logic             sout_valid,
    input  logic             sout_ready,
    output logic             sout_last,
    output logic             busy
);

`ifdef WORD_SERIALIZER_PARITY_EN
    localparam int FRAME_BITS = WIDTH + 1;
`else
    localparam int FRAME_BITS = WIDTH;
`endif
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(FRAME_BITS - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t                  state, state_nx;
    logic [FRAME_BITS-1:0]   shreg, shreg_nx;
    logic [CW-1:0]           cnt, cnt_nx;
    logic [FRAME_BITS-1:0]   load_word;
    logic                    in_fire;
    logic                    out_fire;

`ifdef WORD_SERIALIZER_PARITY_EN
    assign load_word = {^in_data, in_data};
`else
    assign load_word = in_data;
`endif

    // Handshakes: a transfer happens on a rising edge where valid && ready on the same
    // side; valid never depends on ready, and the source holds data until it transfers.
    // in_ready opens mid-frame only while the final bit is leaving, giving gap-free reloads.
    assign sout_valid = (state == SHIFT);
    assign busy       = sout_valid;
    assign sout       = sout_valid ? shreg[0] : IDLE_LEVEL;
    assign sout_last  = sout_valid && (cnt == LAST_CNT);
    assign in_ready   = nrst && ((state == IDLE) || (sout_last && sout_ready));
    assign in_fire    = in_valid && in_ready;
    assign out_fire   = sout_valid && sout_ready;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state <= IDLE;
            shreg <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            shreg <= shreg_nx;
            cnt   <= cnt_nx;
        end
    end

    // A new word outranks the shift: in SHIFT it can only fire alongside the final bit.
    always_comb begin
        state_nx = state;
        shreg_nx = shreg;
        cnt_nx   = cnt;
        if (in_fire) begin
            state_nx = SHIFT;
            shreg_nx = load_word;
            cnt_nx   = '0;
        end else if (out_fire) begin
            if (sout_last) begin
                state_nx = IDLE;
                shreg_nx = '0;
                cnt_nx   = '0;
            end else begin
                shreg_nx = shreg >> 1;
                cnt_nx   = cnt + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_word_serializer.sv
// Self-checking bench for word_serializer: directed scenarios plus randomized streaming
// checked against a bit-queue model built from the accepted words.
module tb_word_serializer;

    localparam int   WIDTH      = 8;
    localparam logic IDLE_LEVEL = 1'b0;
`ifdef WORD_SERIALIZER_PARITY_EN
    localparam int   FB         = WIDTH + 1;
`else
    localparam int   FB         = WIDTH;
`endif

    logic             clk = 1'b0;
    logic             nrst;
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic             sout;
    logic             sout_valid;
    logic             sout_ready;
    logic             sout_last;
    logic             busy;

    int n_tests = 0;
    int n_fail  = 0;

    logic [0:0] exp_q[$];
    logic [0:0] got_q[$];
    logic       got_last_q[$];

    word_serializer #(.WIDTH(WIDTH), .IDLE_LEVEL(IDLE_LEVEL)) dut (
        .clk(clk), .nrst(nrst),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .sout(sout), .sout_valid(sout_valid), .sout_ready(sout_ready),
        .sout_last(sout_last), .busy(busy)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // reference model: a frame is the data bits LSB first, then optional even parity
    function automatic void push_word(input logic [WIDTH-1:0] w);
        for (int i = 0; i < WIDTH; i++) exp_q.push_back(w[i]);
`ifdef WORD_SERIALIZER_PARITY_EN
        exp_q.push_back(^w);
`endif
    endfunction

    task automatic clear_q();
        exp_q.delete();
        got_q.delete();
        got_last_q.delete();
    endtask

    // drivers: inputs change at negedge, sample() settles and records both handshakes
    task automatic sample();
        #1;
        if (in_valid && in_ready) push_word(in_data);
        if (sout_valid && sout_ready) begin
            got_q.push_back(sout);
            got_last_q.push_back(sout_last);
        end
    endtask

    task automatic advance();
        @(negedge clk);
    endtask

    task automatic test_reset();
        nrst = 1'b0; in_valid = 1'b1; in_data = 8'h5A; sout_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        n_tests++; if (sout_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b exp 0", sout_valid); end
        n_tests++; if (sout !== IDLE_LEVEL) begin n_fail++; $display("FAIL reset_sout: got %b exp %b", sout, IDLE_LEVEL); end
        n_tests++; if (sout_last !== 1'b0) begin n_fail++; $display("FAIL reset_last: got %b exp 0", sout_last); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b exp 0", busy); end
        n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b exp 0", in_ready); end
        in_valid = 1'b0;
        advance();
        nrst = 1'b1;
        advance();
        clear_q();
    endtask

    task automatic test_single_word();
        logic [WIDTH-1:0] bits;
        clear_q();
        bits = '0;
        in_data = 8'hA5; in_valid = 1'b1; sout_ready = 1'b1;
        sample();
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL single_idle_ready: got %b exp 1", in_ready); end
        n_tests++; if (sout_valid !== 1'b0) begin n_fail++; $display("FAIL single_latency: got %b exp 0", sout_valid); end
        advance();
        in_valid = 1'b0; in_data = WIDTH'($urandom);
        for (int i = 0; i < FB; i++) begin
            sample();
            n_tests++; if (sout_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid: bit %0d got %b exp 1", i, sout_valid); end
            advance();
        end
        sample();
        n_tests++;
        if (sout_valid !== 1'b0 || sout !== IDLE_LEVEL || busy !== 1'b0) begin
            n_fail++; $display("FAIL single_return_idle: valid %b sout %b busy %b exp 0 %b 0", sout_valid, sout, busy, IDLE_LEVEL);
        end
        advance();
        n_tests++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL single_len: got %0d exp %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_tests++;
            if (got_q[i] !== exp_q[i] || got_last_q[i] !== ((i % FB) == FB - 1)) begin
                n_fail++; $display("FAIL single_bit: idx %0d got %b/%b exp %b/%b", i, got_q[i], got_last_q[i], exp_q[i], (i % FB) == FB - 1);
            end
        end
        for (int i = 0; i < WIDTH && i < got_q.size(); i++) bits[i] = got_q[i];
        n_tests++; if (bits !== 8'hA5) begin n_fail++; $display("FAIL single_word: got %h exp a5", bits); end
    endtask

    task automatic test_back_to_back();
        int nacc;
        clear_q();
        nacc = 0;
        in_data = 8'h0F; in_valid = 1'b1; sout_ready = 1'b1;
        for (int c = 0; c <= 2 * FB + 1; c++) begin
            sample();
            if (c >= 1 && c <= FB) begin
                n_tests++;
                if (in_ready !== (c == FB)) begin n_fail++; $display("FAIL b2b_in_ready: cycle %0d got %b exp %b", c, in_ready, c == FB); end
            end
            if (c >= 1 && c <= 2 * FB) begin
                n_tests++;
                if (sout_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_gap: cycle %0d got %b exp 1", c, sout_valid); end
            end
            if (c == 2 * FB + 1) begin
                n_tests++;
                if (sout_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_end: got %b exp 0", sout_valid); end
            end
            if (in_valid && in_ready) nacc++;
            advance();
            if (nacc == 1) in_data = 8'hF0;
            else if (nacc >= 2) in_valid = 1'b0;
        end
        n_tests++; if (nacc != 2) begin n_fail++; $display("FAIL b2b_accepts: got %0d exp 2", nacc); end
        n_tests++; if (got_q.size() != 2 * FB) begin n_fail++; $display("FAIL b2b_len: got %0d exp %0d", got_q.size(), 2 * FB); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_tests++;
            if (got_q[i] !== exp_q[i] || got_last_q[i] !== ((i % FB) == FB - 1)) begin
                n_fail++; $display("FAIL b2b_bit: idx %0d got %b/%b exp %b/%b", i, got_q[i], got_last_q[i], exp_q[i], (i % FB) == FB - 1);
            end
        end
    endtask

    task automatic test_backpressure();
        int   stall;
        logic held, held_last;
        clear_q();
        stall = 0; held = 1'b0; held_last = 1'b0;
        in_data = 8'h3C; in_valid = 1'b1; sout_ready = 1'b1;
        sample();
        advance();
        in_valid = 1'b0;
        for (int c = 0; c < 40 && got_q.size() < FB; c++) begin
            if (got_q.size() == 2 && stall == 0) sout_ready = 1'b0;
            sample();
            if (!sout_ready) begin
                if (stall == 0) begin
                    held = sout; held_last = sout_last;
                    n_tests++; if (held !== 1'b1) begin n_fail++; $display("FAIL bp_stall_bit: got %b exp 1", held); end
                end else begin
                    n_tests++;
                    if (sout !== held || sout_last !== held_last || sout_valid !== 1'b1) begin
                        n_fail++; $display("FAIL bp_hold: stall %0d got %b/%b/%b exp %b/%b/1", stall, sout, sout_last, sout_valid, held, held_last);
                    end
                end
                stall++;
            end
            advance();
            if (stall >= 3) sout_ready = 1'b1;
        end
        sout_ready = 1'b1;
        n_tests++; if (got_q.size() != FB) begin n_fail++; $display("FAIL bp_len: got %0d exp %0d", got_q.size(), FB); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_tests++;
            if (got_q[i] !== exp_q[i] || got_last_q[i] !== (i == FB - 1)) begin
                n_fail++; $display("FAIL bp_bit: idx %0d got %b/%b exp %b/%b", i, got_q[i], got_last_q[i], exp_q[i], i == FB - 1);
            end
        end
    endtask

    task automatic test_reset_midframe();
        logic [WIDTH-1:0] bits;
        clear_q();
        bits = '0;
        in_data = 8'hFF; in_valid = 1'b1; sout_ready = 1'b1;
        sample();
        advance();
        in_valid = 1'b0;
        for (int c = 0; c < 20 && got_q.size() < 4; c++) begin
            sample();
            advance();
        end
        #2;
        nrst = 1'b0;
        #1;
        n_tests++;
        if (sout_valid !== 1'b0 || sout !== IDLE_LEVEL || sout_last !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL rst_mid_outputs: valid %b sout %b last %b busy %b exp 0 %b 0 0", sout_valid, sout, sout_last, busy, IDLE_LEVEL);
        end
        advance();
        nrst = 1'b1;
        advance();
        sample();
        n_tests++; if (sout_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_resume: got %b exp 0", sout_valid); end
        advance();
        clear_q();
        in_data = 8'h01; in_valid = 1'b1;
        sample();
        advance();
        in_valid = 1'b0;
        for (int c = 0; c < FB + 2; c++) begin
            sample();
            advance();
        end
        n_tests++; if (got_q.size() != FB) begin n_fail++; $display("FAIL rst_mid_len: got %0d exp %0d", got_q.size(), FB); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_tests++;
            if (got_q[i] !== exp_q[i] || got_last_q[i] !== (i == FB - 1)) begin
                n_fail++; $display("FAIL rst_mid_bit: idx %0d got %b/%b exp %b/%b", i, got_q[i], got_last_q[i], exp_q[i], i == FB - 1);
            end
        end
        for (int i = 0; i < WIDTH && i < got_q.size(); i++) bits[i] = got_q[i];
        n_tests++; if (bits !== 8'h01) begin n_fail++; $display("FAIL rst_mid_word: got %h exp 01", bits); end
    endtask

    task automatic test_ignored_input();
        logic pulsed;
        clear_q();
        pulsed = 1'b0;
        in_data = WIDTH'($urandom); in_valid = 1'b1; sout_ready = 1'b1;
        sample();
        advance();
        in_valid = 1'b0;
        for (int c = 0; c < 40 && sout_valid; c++) begin
            if (got_q.size() == 3 && !pulsed) begin in_valid = 1'b1; in_data = 8'h55; end
            sample();
            if (in_valid) begin
                pulsed = 1'b1;
                n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL ign_ready: got %b exp 0", in_ready); end
            end
            advance();
            in_valid = 1'b0;
        end
        n_tests++; if (pulsed !== 1'b1) begin n_fail++; $display("FAIL ign_pulse: got %b exp 1", pulsed); end
        n_tests++; if (sout_valid !== 1'b0) begin n_fail++; $display("FAIL ign_idle: got %b exp 0", sout_valid); end
        n_tests++; if (got_q.size() != FB) begin n_fail++; $display("FAIL ign_len: got %0d exp %0d", got_q.size(), FB); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_tests++;
            if (got_q[i] !== exp_q[i] || got_last_q[i] !== (i == FB - 1)) begin
                n_fail++; $display("FAIL ign_bit: idx %0d got %b/%b exp %b/%b", i, got_q[i], got_last_q[i], exp_q[i], i == FB - 1);
            end
        end
    endtask

`ifdef WORD_SERIALIZER_PARITY_EN
    task automatic test_parity();
        logic [8:0] expv;
        logic [8:0] bits;
        clear_q();
        expv = 9'b1_0000_0111;
        bits = '0;
        in_data = 8'h07; in_valid = 1'b1; sout_ready = 1'b1;
        sample();
        advance();
        in_valid = 1'b0;
        for (int c = 0; c < FB + 2; c++) begin sample(); advance(); end
        for (int i = 0; i < 9 && i < got_q.size(); i++) bits[i] = got_q[i];
        n_tests++; if (bits !== expv) begin n_fail++; $display("FAIL parity_07: got %b exp %b", bits, expv); end
        n_tests++;
        if (got_last_q.size() != 9 || got_last_q[8] !== 1'b1 || got_last_q[7] !== 1'b0) begin
            n_fail++; $display("FAIL parity_last: got %0d bits, last flag position wrong, exp 9 bits with last on 9th");
        end
        clear_q();
        in_data = 8'hA5; in_valid = 1'b1;
        sample();
        advance();
        in_valid = 1'b0;
        for (int c = 0; c < FB + 2; c++) begin sample(); advance(); end
        n_tests++;
        if (got_q.size() != 9 || got_q[8] !== 1'b0) begin n_fail++; $display("FAIL parity_a5: got %0d bits, exp 9 with parity 0", got_q.size()); end
    endtask
`endif

    task automatic test_random_stream();
        int   sent;
        logic prev_stall, held, held_last;
        localparam int N = 150;
        clear_q();
        sent = 0; prev_stall = 1'b0; held = 1'b0; held_last = 1'b0;
        in_valid = 1'b0;
        for (int c = 0; c < 8000 && (sent < N || sout_valid); c++) begin
            if (!in_valid && sent < N && $urandom_range(0, 3) != 0) begin
                in_valid = 1'b1; in_data = WIDTH'($urandom);
            end
            sout_ready = ($urandom_range(0, 3) != 0);
            sample();
            if (prev_stall) begin
                n_tests++;
                if (sout !== held || sout_last !== held_last || sout_valid !== 1'b1) begin
                    n_fail++; $display("FAIL rand_hold: cycle %0d got %b/%b exp %b/%b", c, sout, sout_last, held, held_last);
                end
            end
            prev_stall = sout_valid && !sout_ready;
            held = sout; held_last = sout_last;
            if (in_valid && in_ready) begin
                sent++;
                advance();
                in_valid = 1'b0;
            end else begin
                advance();
            end
        end
        sout_ready = 1'b1;
        n_tests++; if (sent != N) begin n_fail++; $display("FAIL rand_sent: got %0d exp %0d", sent, N); end
        n_tests++; if (got_q.size() != N * FB) begin n_fail++; $display("FAIL rand_len: got %0d exp %0d", got_q.size(), N * FB); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_tests++;
            if (got_q[i] !== exp_q[i] || got_last_q[i] !== ((i % FB) == FB - 1)) begin
                n_fail++; $display("FAIL rand_bit: idx %0d got %b/%b exp %b/%b", i, got_q[i], got_last_q[i], exp_q[i], (i % FB) == FB - 1);
            end
        end
    endtask

    initial begin
        nrst = 1'b0; in_valid = 1'b0; in_data = '0; sout_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_single_word();
        test_back_to_back();
        test_backpressure();
        test_reset_midframe();
        test_ignored_input();
`ifdef WORD_SERIALIZER_PARITY_EN
        test_parity();
`endif
        test_random_stream();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
